// File: rtl/synth_clock_divider_bank.sv
// Clock-generation bank: square-wave speaker tone, clk/2 PS/2 clock and a
// periodic note gate whose on-length is set by a 2-bit duration code.
module synth_clock_divider_bank #(
  parameter int unsigned TONE_W      = 20,
  parameter int unsigned BEAT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TONE_W-1:0] inCount,
  input  logic [1:0]        duration,
  output logic              speaker,
  output logic              kclk,
  output logic              playSound
);

  localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [BW:0] LEN_Q1  = (BW+1)'(BEAT_CYCLES / 4);
  localparam logic [BW:0] LEN_Q2  = (BW+1)'(BEAT_CYCLES / 2);
  localparam logic [BW:0] LEN_Q3  = (BW+1)'((BEAT_CYCLES / 4) * 3);
  localparam logic [BW:0] LEN_Q4  = (BW+1)'(BEAT_CYCLES);
  localparam logic [BW-1:0] BLAST = BW'(BEAT_CYCLES - 1);

  logic [TONE_W-1:0] tcnt;
  logic [BW-1:0]     bcnt;
  logic [BW:0]       on_len;

  // Tone divider: >= compare lets a reduced inCount wrap at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt    <= '0;
      speaker <= 1'b0;
    end else if (inCount == '0) begin
      tcnt    <= '0;
      speaker <= 1'b0;
    end else if (tcnt >= inCount - TONE_W'(1)) begin
      tcnt    <= '0;
      speaker <= ~speaker;
    end else begin
      tcnt    <= tcnt + TONE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) kclk <= 1'b0;
    else      kclk <= ~kclk;
  end

  always_comb begin
    on_len = LEN_Q1;
    case (duration)
      2'd0: on_len = LEN_Q1;
      2'd1: on_len = LEN_Q2;
      2'd2: on_len = LEN_Q3;
      2'd3: on_len = LEN_Q4;
      default: on_len = LEN_Q1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt      <= '0;
      playSound <= 1'b0;
    end else begin
      bcnt      <= (bcnt == BLAST) ? '0 : bcnt + BW'(1);
      playSound <= ({1'b0, bcnt} < on_len);
    end
  end

endmodule

// File: tb/tb_synth_clock_divider_bank.sv
// Directed bench for synth_clock_divider_bank with a short beat (8 cycles).
module tb_synth_clock_divider_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] inCount = '0;
  logic [1:0]  duration = '0;
  logic        speaker, kclk, playSound;

  int errors = 0;
  int checks = 0;

  synth_clock_divider_bank #(.TONE_W(20), .BEAT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .inCount(inCount), .duration(duration),
    .speaker(speaker), .kclk(kclk), .playSound(playSound)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Holds reset for two edges with the given inputs, then releases it.
  task automatic reset_dut(input logic [19:0] ic, input logic [1:0] d);
    rst = 1'b0;
    inCount = ic;
    duration = d;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [11:0] tone3;
    logic [8:0]  mid;
    logic [7:0]  pat;
    logic [5:0]  midbeat;
    int          first, second;

    // Reset state and kclk start-up
    rst = 1'b0; inCount = 20'd5; duration = 2'd0;
    repeat (3) tick();
    check("rst_speaker", speaker, 0);
    check("rst_kclk", kclk, 0);
    check("rst_play", playSound, 0);
    rst = 1'b1;
    tick(); check("kclk_e1", kclk, 1);
    tick(); check("kclk_e2", kclk, 0);
    tick(); check("kclk_e3", kclk, 1);
    tick(); check("kclk_e4", kclk, 0);
    check("spk_before_first_toggle", speaker, 0);
    tick(); check("spk_inc5_e5", speaker, 1);
    rst = 1'b0;
    tick();
    check("rst_mid_period_spk", speaker, 0);
    check("rst_mid_period_kclk", kclk, 0);
    check("rst_mid_beat_play", playSound, 0);

    // Tone, inCount=3: edges 1..12 (MSB = edge 1)
    reset_dut(20'd3, 2'd0);
    tone3 = 12'b001110001110;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("tone3_e%0d", k + 1), speaker, tone3[11-k]);
    end
    inCount = 20'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("tone1_e%0d", k + 13), speaker, (k % 2 == 0) ? 1 : 0);
    end

    // Mid-period change 10 -> 4 once tcnt reaches 7
    reset_dut(20'd10, 2'd0);
    repeat (7) tick();
    check("mid_pre", speaker, 0);
    inCount = 20'd4;
    mid = 9'b111100001;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("mid_e%0d", k + 8), speaker, mid[8-k]);
    end
    inCount = 20'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("silence_%0d", k), speaker, 0);
    end
    inCount = 20'd2;
    tick(); check("unmute_e1", speaker, 0);
    tick(); check("unmute_e2", speaker, 1);

    // Duration codes over two beats
    for (int d = 0; d < 4; d++) begin
      case (d)
        0: pat = 8'b11000000;
        1: pat = 8'b11110000;
        2: pat = 8'b11111100;
        default: pat = 8'b11111111;
      endcase
      reset_dut(20'd0, 2'(d));
      for (int k = 0; k < 16; k++) begin
        tick();
        check($sformatf("dur%0d_e%0d", d, k + 1), playSound, pat[7-(k%8)]);
      end
    end

    // Duration 0 -> 2 at bcnt=3 (edges 1..9)
    reset_dut(20'd0, 2'd0);
    tick(); check("mb_e1", playSound, 1);
    tick(); check("mb_e2", playSound, 1);
    tick(); check("mb_e3", playSound, 0);
    duration = 2'd2;
    midbeat = 6'b111001;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("mb_e%0d", k + 4), playSound, midbeat[5-k]);
    end

    // Large count: first toggle latency and full period
    reset_dut(20'd12345, 2'd0);
    first = 0;
    for (int k = 1; k <= 20000; k++) begin
      tick();
      if (speaker) begin first = k; break; end
    end
    check("big_first_rise", first, 12345);
    second = 0;
    for (int k = 1; k <= 40000; k++) begin
      logic prev;
      prev = speaker;
      tick();
      if (speaker && !prev) begin second = k; break; end
    end
    check("big_period", second, 24690);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
